// File: rtl/dither_chk18.sv
// dither_chk18: checker for the 18-tap dither generator stream (search, verify, locked free-run with windowed unlock)
module dither_chk18 #(
  parameter int LOCK_CNT   = 32,
  parameter int WIN        = 64,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_en,
  input  logic [1:0]       dither_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);
  localparam logic [1:0] S_SEARCH = 2'b00;
  localparam logic [1:0] S_VERIFY = 2'b01;
  localparam logic [1:0] S_LOCKED = 2'b10;
  logic [1:0]       r_state, w_state;
  logic [18:0]      r_h, w_h;
  logic [4:0]       r_fill, w_fill;
  logic [7:0]       r_match, w_match;
  logic [15:0]      r_win, w_win, r_bad, w_bad;
  logic             r_pulse, w_pulse;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt;
  logic             w_legal, w_bit, w_p, w_err;
  logic [18:0]      w_h_rx;
  logic [4:0]       w_fill_inc;
  logic [7:0]       w_match_inc;
  logic [15:0]      w_win_inc, w_bad_inc;
  assign w_legal     = dither_in[0];
  assign w_bit       = dither_in[1];
  assign w_p         = r_h[18] ^ r_h[17] ^ r_h[13] ^ r_h[12];
  assign w_err       = ~w_legal | (w_bit != w_p);
  assign w_h_rx      = {r_h[17:0], w_bit};
  assign w_fill_inc  = r_fill + 5'd1;
  assign w_match_inc = r_match + 8'd1;
  assign w_win_inc   = r_win + 16'd1;
  assign w_bad_inc   = r_bad + 16'd1;
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_SEARCH;
      r_h       <= '0;
      r_fill    <= '0;
      r_match   <= '0;
      r_win     <= '0;
      r_bad     <= '0;
      r_pulse   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state;
      r_h       <= w_h;
      r_fill    <= w_fill;
      r_match   <= w_match;
      r_win     <= w_win;
      r_bad     <= w_bad;
      r_pulse   <= w_pulse;
      r_err_cnt <= w_err_cnt;
    end
  end
  // next-state: every register holds unless a sample strobe arrives
  always_comb begin
    w_state   = r_state;
    w_h       = r_h;
    w_fill    = r_fill;
    w_match   = r_match;
    w_win     = r_win;
    w_bad     = r_bad;
    w_pulse   = 1'b0;
    w_err_cnt = r_err_cnt;
    if (clk_en) begin
      case (r_state)
        S_SEARCH: begin
          if (!w_legal) w_fill = '0;
          else begin
            w_h    = w_h_rx;
            w_fill = w_fill_inc;
            if (w_fill_inc == 5'd19) begin
              w_fill = '0;
              if (w_h_rx != '0) begin
                w_state = S_VERIFY;
                w_match = '0;
              end
            end
          end
        end
        S_VERIFY: begin
          if (w_err) begin
            w_state = S_SEARCH;
            w_fill  = '0;
          end else begin
            w_h     = w_h_rx;
            w_match = w_match_inc;
            if (w_match_inc == 8'(LOCK_CNT)) begin
              w_state = S_LOCKED;
              w_win   = '0;
              w_bad   = '0;
            end
          end
        end
        S_LOCKED: begin
          w_h     = {r_h[17:0], w_p};
          w_pulse = w_err;
          if (w_err && r_err_cnt != '1) w_err_cnt = r_err_cnt + ERR_W'(1);
          if (w_err && w_bad_inc == 16'(UNLOCK_ERR)) begin
            w_state = S_SEARCH;
            w_fill  = '0;
            w_win   = '0;
            w_bad   = '0;
          end else if (w_win_inc == 16'(WIN)) begin
            w_win = '0;
            w_bad = '0;
          end else begin
            w_win = w_win_inc;
            w_bad = w_err ? w_bad_inc : r_bad;
          end
        end
        default: w_state = S_SEARCH;
      endcase
      if (err_clr) w_err_cnt = '0;
    end
  end
  // outputs come straight from registers
  always_comb begin
    locked    = (r_state == S_LOCKED);
    err_pulse = r_pulse;
    err_cnt   = r_err_cnt;
    state     = r_state;
  end
endmodule

// File: tb/tb_dither_chk18.sv
// tb_dither_chk18: directed and random stimulus against a queue-based reference of the checker
module tb_dither_chk18;
  localparam int LOCK_CNT = 32, WIN = 64, UNLOCK_ERR = 4, ERR_W = 16;
  logic clk = 1'b0, rstn = 1'b0, clk_en = 1'b0, err_clr = 1'b0;
  logic [1:0] dither_in = 2'b01;
  logic locked, err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0] state;

  dither_chk18 #(.LOCK_CNT(LOCK_CNT), .WIN(WIN), .UNLOCK_ERR(UNLOCK_ERR), .ERR_W(ERR_W)) dut (
    .clk(clk), .rstn(rstn), .clk_en(clk_en), .dither_in(dither_in), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .state(state));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit y[20000];
  int gp;
  int m_mode, m_match, m_win, m_bad, m_errc;
  bit m_pulse;
  bit q[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sym(input bit b);
    return b ? 2'b11 : 2'b01;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_match = 0; m_win = 0; m_bad = 0; m_errc = 0; m_pulse = 0;
    q.delete();
  endtask

  task automatic model(input bit en, input logic [1:0] s, input bit clr);
    bit legal, b, p, e, any;
    m_pulse = 0;
    if (!en) return;
    legal = s[0];
    b = s[1];
    if (m_mode == 0) begin
      if (!legal) q.delete();
      else begin
        q.push_back(b);
        if (q.size() == 19) begin
          any = 0;
          foreach (q[i]) any |= q[i];
          if (any) begin m_mode = 1; m_match = 0; end
          else q.delete();
        end
      end
    end else begin
      p = q[0] ^ q[1] ^ q[5] ^ q[6];
      e = !legal || (b != p);
      if (m_mode == 1) begin
        if (e) begin m_mode = 0; q.delete(); end
        else begin
          q.push_back(b); void'(q.pop_front());
          m_match++;
          if (m_match == LOCK_CNT) begin m_mode = 2; m_win = 0; m_bad = 0; end
        end
      end else begin
        q.push_back(p); void'(q.pop_front());
        m_pulse = e;
        if (e && m_errc < (1 << ERR_W) - 1) m_errc++;
        m_win++;
        if (e) m_bad++;
        if (e && m_bad == UNLOCK_ERR) begin
          m_mode = 0; q.delete(); m_win = 0; m_bad = 0;
        end else if (m_win == WIN) begin
          m_win = 0; m_bad = 0;
        end
      end
    end
    if (clr) m_errc = 0;
  endtask

  task automatic step(input bit en, input logic [1:0] s, input bit clr);
    clk_en = en; dither_in = s; err_clr = clr;
    model(en, s, clr);
    @(posedge clk); #1;
    check("state", int'(state), m_mode);
    check("locked", int'(locked), int'(m_mode == 2));
    check("err_pulse", int'(err_pulse), int'(m_pulse));
    check("err_cnt", int'(err_cnt), m_errc);
  endtask

  task automatic clean(input int n);
    repeat (n) begin step(1'b1, sym(y[gp]), 1'b0); gp++; end
  endtask

  task automatic flip(input bit clr);
    step(1'b1, sym(!y[gp]), clr); gp++;
  endtask

  task automatic align();
    for (int i = 0; i < WIN && m_win != 0; i++) clean(1);
    check("align", m_win, 0);
  endtask

  task automatic do_reset();
    clk_en = 0; rstn = 0;
    model_reset();
    @(posedge clk); #1;
    rstn = 1;
  endtask

  initial begin
    for (int k = 0; k < 20000; k++)
      y[k] = (k < 18) ? 1'b0 : (k == 18) ? 1'b1 : (y[k-19] ^ y[k-18] ^ y[k-14] ^ y[k-13]);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_pulse", int'(err_pulse), 0);
    check("rst_cnt", int'(err_cnt), 0);
    rstn = 1;
    gp = 0;
    for (int i = 0; i < 10000; i++) begin
      clean(1);
      if (i == 49) check("pre_lock", int'(locked), 0);
      if (i == 50) check("lock51", int'(locked), 1);
    end
    check("clean_cnt", int'(err_cnt), 0);
    flip(1'b0);
    check("flip_pulse", int'(err_pulse), 1);
    check("flip_cnt", int'(err_cnt), 1);
    check("flip_locked", int'(locked), 1);
    clean(1);
    check("pulse_width", int'(err_pulse), 0);
    clean(100);
    step(1'b1, 2'b00, 1'b0); gp++;
    check("illegal_cnt", int'(err_cnt), 2);
    check("illegal_locked", int'(locked), 1);
    clean(100);
    step(1'b1, sym(y[gp]), 1'b1); gp++;
    check("clr_cnt", int'(err_cnt), 0);
    align();
    for (int j = 0; j < 4; j++) begin
      flip(1'b0);
      check("burst_locked", int'(locked), int'(j < 3));
    end
    check("burst_state", int'(state), 0);
    check("burst_cnt", int'(err_cnt), 4);
    check("burst_pulse", int'(err_pulse), 1);
    for (int i = 0; i < 51; i++) begin
      clean(1);
      if (i == 49) check("relock_pre", int'(locked), 0);
      if (i == 50) check("relock51", int'(locked), 1);
    end
    check("relock_cnt", int'(err_cnt), 4);
    step(1'b1, sym(y[gp]), 1'b1); gp++;
    align();
    flip(1'b0); clean(29);
    flip(1'b0); clean(29);
    flip(1'b0); clean(29);
    flip(1'b0);
    check("win_locked", int'(locked), 1);
    check("win_state", int'(state), 2);
    check("win_cnt", int'(err_cnt), 4);
    flip(1'b1);
    check("clr_prio_cnt", int'(err_cnt), 0);
    check("clr_prio_pulse", int'(err_pulse), 1);
    flip(1'b0);
    check("pre_rst_cnt", int'(err_cnt), 1);
    #2 rstn = 0;
    #1;
    model_reset();
    check("arst_state", int'(state), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_pulse", int'(err_pulse), 0);
    check("arst_cnt", int'(err_cnt), 0);
    clk_en = 0;
    @(posedge clk); #1;
    rstn = 1;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 2'b01, 1'b0);
      check("const_search", int'(state), 0);
    end
    do_reset();
    gp = 0;
    for (int s = 0; s < 51; s++) begin
      step(1'b0, 2'($urandom), 1'b0);
      step(1'b0, 2'($urandom), 1'b0);
      clean(1);
      if (s == 49) check("duty_pre", int'(locked), 0);
      if (s == 50) check("duty_lock", int'(locked), 1);
    end
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit en;
      en = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 199);
      if (!en) step(1'b0, 2'($urandom), 1'b0);
      else begin
        if (r < 2) step(1'b1, sym(!y[gp]), 1'b0);
        else if (r < 3) step(1'b1, {1'($urandom), 1'b0}, 1'b0);
        else step(1'b1, sym(y[gp]), ($urandom_range(0, 299) == 0));
        gp++;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dither_chk18.md
# dither_chk18

Receive-side checker for the ±1 dither stream from the 18-tap dither generator in the DAC digital path. It decodes 2-bit signed dither symbols into sequence bits and synchronises to the generator's recurrence. Once locked, it free-runs its own copy of the sequence, counts symbol errors and drops lock on sustained mismatch. It sits on the dither tap for bring-up and BIST, and is sampled on the same clock-enable strobe as the generator.

## Interface
- LOCK_CNT, 32: consecutive correct predictions in VERIFY required to enter LOCKED (1..255).
- WIN, 64: LOCKED error-window length, in samples (2..65535).
- UNLOCK_ERR, 4: errors within one window that force SEARCH (1..WIN).
- ERR_W, 16: width of err_cnt.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- clk_en  in  1  sample strobe; one dither symbol consumed per cycle with clk_en=1.
- dither_in  in  2  signed symbol: 2'b01=+1 (bit 0), 2'b11=-1 (bit 1), 2'b00/2'b10 illegal.
- err_clr  in  1  synchronous clear of err_cnt; has priority over an increment in the same cycle.
- locked  out  1  high in LOCKED.
- err_pulse  out  1  one-cycle pulse per errored sample while LOCKED.
- err_cnt  out  ERR_W  saturating count of LOCKED errors.
- state  out  2  00 SEARCH, 01 VERIFY, 10 LOCKED.

## Operation
- Sequence bit y(k) = y(k-19) ^ y(k-18) ^ y(k-14) ^ y(k-13). A 19-bit history register h holds y(k-1)..y(k-19).
- From generator reset, the stream is y(0..17)=0 (+1) and y(18)=1 (-1), then follows the recurrence.
- All state advances only on cycles with clk_en=1. With clk_en=0, every register holds and err_pulse=0.
- SEARCH
  - Shift decoded bits into h and count fill up to 19.
  - An illegal symbol clears the fill count to 0.
  - When fill reaches 19: if h≠0, go to VERIFY with match count=0; otherwise restart the fill. This rejects a constant +1 stream.
- VERIFY
  - Predict p from h, then shift the received bit into h.
  - Received bit = p: match count +1.
  - Received bit ≠ p, or illegal symbol: go to SEARCH with fill=0.
  - Match count reaches LOCK_CNT: go to LOCKED with window counter=0 and bad counter=0.
- LOCKED
  - Predict p and shift p, not the received bit, into h, so the checker free-runs.
  - Error = received bit ≠ p, or illegal symbol.
  - On error: err_pulse=1, err_cnt +1 (saturates at all-ones), bad counter +1.
  - Window counter counts samples; at WIN samples, both window and bad counters reset to 0.
  - If bad counter reaches UNLOCK_ERR in the same sample as the window wrap, unlock wins.
  - Unlock: go to SEARCH, fill=0, and clear the window and bad counters. err_cnt is held.
- A single flipped sample in LOCKED yields exactly one error; errors do not propagate.
- err_cnt is cleared only by rstn or err_clr. It never increments outside LOCKED.

## Timing
- Reset values: state=SEARCH, h=0, all counters 0, locked=0, err_pulse=0, err_cnt=0.
- All outputs are registered and reflect the sample consumed at the same clk edge (1-cycle latency from the strobe cycle).
- Lock from a clean stream takes 19+LOCK_CNT enabled samples: with defaults, locked rises at the edge consuming sample 51.
- err_pulse is exactly one clk cycle wide, even when clk_en stays high continuously.
- Unlock: locked falls at the edge consuming the UNLOCK_ERR-th windowed error. err_pulse is also 1 on that edge.
- rstn assertion mid-operation clears everything asynchronously. Reacquisition restarts from SEARCH.

## Test plan
- Reset, then feed the generator stream from its reset (clk_en=1 every cycle) -> locked=0 through sample 50, locked=1 from sample 51, err_cnt=0 over 10000 samples.
- After lock, invert one symbol (2'b01<->2'b11) -> err_pulse high for 1 cycle, err_cnt=1, locked stays 1. Repeat with 2'b00 -> err_cnt=2.
- After lock, corrupt 4 consecutive samples -> locked falls on the 4th, state=SEARCH, err_cnt=4. Then the clean stream -> relock after 51 more samples, err_cnt still 4.
- 3 errors spaced 30 samples apart, then a 4th error after the 64-sample window wraps -> never unlocks, err_cnt=4.
- Constant 2'b01 for 1000 samples -> state never leaves SEARCH, locked=0.
- Clean stream with clk_en duty 1-in-3 -> lock after 51 strobes. Assert err_clr together with an error -> err_cnt=0. Pulse rstn mid-LOCKED -> all outputs 0 on the same cycle.
